// File: rtl/clk_rate_ctrl_if.sv
// rtl/clk_rate_ctrl_if.sv - control and status bundle for clk_rate_ctrl
interface clk_rate_ctrl_if;
   logic       run;
   logic       btn_up;
   logic       btn_down;
   logic       clk_out;
   logic       tick;
   logic [2:0] rate;
   logic       pending;

   modport master (
      output run, btn_up, btn_down,
      input  clk_out, tick, rate, pending
   );

   modport slave (
      input  run, btn_up, btn_down,
      output clk_out, tick, rate, pending
   );
endinterface

// File: rtl/clk_rate_ctrl.sv
// rtl/clk_rate_ctrl.sv - button-driven saturating rate level and glitch-free clock divider
// Optional macro CLK_RATE_CTRL_BTN_SYNC_EN adds a 2-flop synchronizer per button.
module clk_rate_ctrl #(
   parameter int CNT_W     = 24,
   parameter int BASE_HALF = 1000,
   parameter int RATE_MAX  = 7,
   parameter int RATE_INIT = 0
) (
   input  logic          clk_in,
   input  logic          reset,
   clk_rate_ctrl_if.slave bus
);
   localparam logic [2:0] RATE_MAX3  = 3'(RATE_MAX);
   localparam logic [2:0] RATE_INIT3 = 3'(RATE_INIT);

   logic             up_s, dn_s;
   logic             up_q, up_d, dn_q, dn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [2:0]       rate_q, rate_d;
   logic [2:0]       pend_rate_q, pend_rate_d;
   logic             pending_q, pending_d;

   logic [CNT_W-1:0] half_m1;
   logic             at_end, apply, up_press, dn_press;
   logic [2:0]       base, inc, dec;

`ifdef CLK_RATE_CTRL_BTN_SYNC_EN
   logic [1:0] up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;

   always_comb begin
      up_sync_d = {up_sync_q[0], bus.btn_up};
      dn_sync_d = {dn_sync_q[0], bus.btn_down};
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         up_sync_q <= 2'b00;
         dn_sync_q <= 2'b00;
      end else begin
         up_sync_q <= up_sync_d;
         dn_sync_q <= dn_sync_d;
      end
   end

   assign up_s = up_sync_q[1];
   assign dn_s = dn_sync_q[1];
`else
   assign up_s = bus.btn_up;
   assign dn_s = bus.btn_down;
`endif

   always_comb begin
      // H may equal 2^CNT_W; it wraps to 0 and H-1 becomes all ones, which is still correct
      half_m1  = (CNT_W'(BASE_HALF) << rate_q) - CNT_W'(1);
      at_end   = bus.run & (cnt_q == half_m1);
      apply    = pending_q & (at_end | ~bus.run);
      up_press = up_s & ~up_q;
      dn_press = dn_s & ~dn_q;
      up_d     = up_s;
      dn_d     = dn_s;

      base = pending_q ? pend_rate_q : rate_q;
      inc  = (base >= RATE_MAX3) ? RATE_MAX3 : base + 3'd1;
      dec  = (base == 3'd0) ? 3'd0 : base - 3'd1;

      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      if (bus.run) begin
         if (at_end) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pending_q) begin
         cnt_d = '0;
      end

      // a press on the apply edge is compared against the rate being applied now
      rate_d      = apply ? pend_rate_q : rate_q;
      pend_rate_d = pend_rate_q;
      pending_d   = pending_q & ~apply;
      if (up_press ^ dn_press) begin
         pend_rate_d = up_press ? inc : dec;
         pending_d   = (pend_rate_d != rate_d);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         up_q        <= 1'b0;
         dn_q        <= 1'b0;
         cnt_q       <= '0;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         rate_q      <= RATE_INIT3;
         pend_rate_q <= RATE_INIT3;
         pending_q   <= 1'b0;
      end else begin
         up_q        <= up_d;
         dn_q        <= dn_d;
         cnt_q       <= cnt_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         rate_q      <= rate_d;
         pend_rate_q <= pend_rate_d;
         pending_q   <= pending_d;
      end
   end

   assign bus.clk_out = clk_out_q;
   assign bus.tick    = tick_q;
   assign bus.rate    = rate_q;
   assign bus.pending = pending_q;
endmodule

// File: tb/tb_clk_rate_ctrl.sv
// tb/tb_clk_rate_ctrl.sv - directed self-checking bench for clk_rate_ctrl
// Press latency expectation follows CLK_RATE_CTRL_BTN_SYNC_EN.
module tb_clk_rate_ctrl;
`ifdef CLK_RATE_CTRL_BTN_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   clk_rate_ctrl_if bus ();

   clk_rate_ctrl #(
      .CNT_W    (24),
      .BASE_HALF(2),
      .RATE_MAX (3),
      .RATE_INIT(0)
   ) dut (
      .clk_in(clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #1 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset(input logic up, input logic dn, input logic rn);
      bus.btn_up   = up;
      bus.btn_down = dn;
      bus.run      = rn;
      reset        = 1'b0;
      cyc(3);
      reset = 1'b1;
   endtask

   task automatic press_up();
      bus.btn_up = 1'b1;
      cyc(1);
      bus.btn_up = 1'b0;
      cyc(1);
   endtask

   task automatic press_dn();
      bus.btn_down = 1'b1;
      cyc(1);
      bus.btn_down = 1'b0;
      cyc(1);
   endtask

   task automatic measure_half(output int n);
      logic v;
      v = bus.clk_out;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (bus.clk_out == v && n < 100);
   endtask

   task automatic test_reset();
      bit exp_clk [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
      bit exp_tick[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b1;
      bus.run      = 1'b1;
      reset        = 1'b0;
      cyc(3);
      tests_run++;
      if (bus.clk_out !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_out: got %b expected 0", bus.clk_out); end
      tests_run++;
      if (bus.tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
      tests_run++;
      if (bus.rate !== 3'd0) begin tests_failed++; $display("FAIL reset_rate: got %0d expected 0", bus.rate); end
      tests_run++;
      if (bus.pending !== 1'b0) begin tests_failed++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         tests_run++;
         if (bus.clk_out !== exp_clk[k] || bus.tick !== exp_tick[k] || bus.pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wave[%0d]: got clk_out=%b tick=%b pending=%b expected %b %b 0",
                     k, bus.clk_out, bus.tick, bus.pending, exp_clk[k], exp_tick[k]);
         end
      end
      tests_run++;
      if (bus.rate !== 3'd0) begin tests_failed++; $display("FAIL reset_held_rate: got %0d expected 0", bus.rate); end
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      cyc(2);
   endtask

   task automatic test_single_up();
      int n;
      apply_reset(1'b0, 1'b0, 1'b1);
      cyc(2);
      bus.btn_up = 1'b1;
      cyc(1);
      bus.btn_up = 1'b0;
      cyc(LAT - 1);
      tests_run++;
      if (bus.pending !== 1'b1 || bus.rate !== 3'd0) begin
         tests_failed++;
         $display("FAIL up_pending: got pending=%b rate=%0d expected 1 0", bus.pending, bus.rate);
      end
      cyc(1);
      tests_run++;
      if (bus.pending !== 1'b0 || bus.rate !== 3'd1) begin
         tests_failed++;
         $display("FAIL up_applied: got pending=%b rate=%0d expected 0 1", bus.pending, bus.rate);
      end
      for (int k = 0; k < 2; k++) begin
         measure_half(n);
         tests_run++;
         if (n != 4) begin tests_failed++; $display("FAIL up_half[%0d]: got %0d cycles expected 4", k, n); end
      end
   endtask

   task automatic test_saturation();
      int n;
      apply_reset(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) press_up();
      cyc(LAT + 2);
      tests_run++;
      if (bus.rate !== 3'd3 || bus.pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_up: got rate=%0d pending=%b expected 3 0", bus.rate, bus.pending);
      end
      bus.run = 1'b1;
      measure_half(n);
      tests_run++;
      if (n != 16) begin tests_failed++; $display("FAIL sat_half: got %0d cycles expected 16", n); end

      apply_reset(1'b0, 1'b0, 1'b1);
      bus.btn_down = 1'b1;
      cyc(LAT);
      tests_run++;
      if (bus.rate !== 3'd0 || bus.pending !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_down_zero: got rate=%0d pending=%b expected 0 0", bus.rate, bus.pending);
      end
      bus.btn_down = 1'b0;
      cyc(2);
   endtask

   task automatic test_accumulate();
      int n;
      apply_reset(1'b0, 1'b0, 1'b0);
      press_up();
      press_up();
      cyc(LAT + 1);
      tests_run++;
      if (bus.rate !== 3'd2) begin tests_failed++; $display("FAIL acc_start: got rate=%0d expected 2", bus.rate); end
      bus.run = 1'b1;
      press_dn();
      press_dn();
      press_up();
      cyc(1);
      tests_run++;
      if (bus.pending !== 1'b1 || bus.rate !== 3'd2) begin
         tests_failed++;
         $display("FAIL acc_queued: got pending=%b rate=%0d expected 1 2", bus.pending, bus.rate);
      end
      cyc(1);
      tests_run++;
      if (bus.pending !== 1'b0 || bus.rate !== 3'd1 || bus.clk_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL acc_applied: got pending=%b rate=%0d clk_out=%b expected 0 1 1",
                  bus.pending, bus.rate, bus.clk_out);
      end
      measure_half(n);
      tests_run++;
      if (n != 4) begin tests_failed++; $display("FAIL acc_half: got %0d cycles expected 4", n); end
   endtask

   task automatic test_simultaneous();
      apply_reset(1'b0, 1'b0, 1'b1);
      bus.btn_up   = 1'b1;
      bus.btn_down = 1'b1;
      cyc(LAT);
      tests_run++;
      if (bus.pending !== 1'b0) begin tests_failed++; $display("FAIL simul_pending: got %b expected 0", bus.pending); end
      cyc(4);
      tests_run++;
      if (bus.rate !== 3'd0) begin tests_failed++; $display("FAIL simul_rate: got %0d expected 0", bus.rate); end
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      cyc(2);
   endtask

   task automatic test_frozen();
      int n;
      apply_reset(1'b0, 1'b0, 1'b1);
      cyc(2);
      bus.run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         tests_run++;
         if (bus.clk_out !== 1'b1 || bus.tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL frozen_hold[%0d]: got clk_out=%b tick=%b expected 1 0", k, bus.clk_out, bus.tick);
         end
      end
      bus.btn_up = 1'b1;
      cyc(1);
      bus.btn_up = 1'b0;
      cyc(LAT);
      tests_run++;
      if (bus.rate !== 3'd1 || bus.pending !== 1'b0 || dut.cnt_q !== 24'd0 || bus.clk_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL frozen_apply: got rate=%0d pending=%b cnt=%0d clk_out=%b expected 1 0 0 1",
                  bus.rate, bus.pending, dut.cnt_q, bus.clk_out);
      end
      bus.run = 1'b1;
      measure_half(n);
      tests_run++;
      if (n != 4 || bus.clk_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL frozen_resume: got %0d cycles clk_out=%b expected 4 0", n, bus.clk_out);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset(1'b0, 1'b0, 1'b1);
      cyc(2);
      bus.btn_up = 1'b1;
      cyc(1);
      bus.btn_up = 1'b0;
      cyc(LAT - 1);
      tests_run++;
      if (bus.pending !== 1'b1) begin tests_failed++; $display("FAIL mid_pending: got %b expected 1", bus.pending); end
      reset = 1'b0;
      cyc(1);
      tests_run++;
      if (bus.rate !== 3'd0 || bus.pending !== 1'b0 || bus.clk_out !== 1'b0 || bus.tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: got rate=%0d pending=%b clk_out=%b tick=%b expected 0 0 0 0",
                  bus.rate, bus.pending, bus.clk_out, bus.tick);
      end
      bus.btn_up = 1'b1;
      cyc(2);
      reset = 1'b1;
      n = 0;
      while (bus.pending !== 1'b1 && n < 50) begin
         cyc(1);
         n++;
      end
      tests_run++;
      if (n != LAT) begin tests_failed++; $display("FAIL press_latency: got %0d cycles expected %0d", n, LAT); end
      cyc(1);
      tests_run++;
      if (bus.rate !== 3'd1) begin tests_failed++; $display("FAIL held_press_rate: got %0d expected 1", bus.rate); end
      bus.btn_up = 1'b0;
      cyc(2);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bus.run      = 1'b0;
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      test_reset();
      test_single_up();
      test_saturation();
      test_accumulate();
      test_simultaneous();
      test_frozen();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/clk_rate_ctrl.md
# clk_rate_ctrl

Button-driven rate controller and programmable clock divider for the button board. It turns debounced up/down button presses into a saturating rate level and runs a half-period counter whose terminal count is `BASE_HALF << rate`. Rate changes are applied only at a half-period boundary, so `clk_out` never produces a runt pulse. Downstream blocks use `clk_out` as a visible slow clock (LED) and `tick` as a one-cycle enable.

## Interface
- `CNT_W`, 24: width of the half-period counter.
- `BASE_HALF`, 1000: half-period in `clk_in` cycles at rate 0. Must be ≥ 1.
- `RATE_MAX`, 7: highest rate level. Must be ≤ 7. `BASE_HALF << RATE_MAX` must be ≤ 2^CNT_W.
- `RATE_INIT`, 0: rate level loaded at reset. Must be ≤ `RATE_MAX`.

Ports:
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  1 = divider counts; 0 = divider frozen.
- `btn_up`  in  1  debounced level; a rising edge requests rate+1.
- `btn_down`  in  1  debounced level; a rising edge requests rate−1.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse on each 0→1 transition of `clk_out`.
- `rate`  out  3  active rate level.
- `pending`  out  1  a rate change is queued and not yet applied.

## Operation
- **Edge detect.** Each button has a previous-value register. A press is `btn & ~btn_q`. The `btn_q` registers clear to 0 on reset, so a button held through reset counts as one press.
- **Request.** On an up press, `pend_rate` becomes `base + 1`, saturating at `RATE_MAX`. On a down press, it becomes `base − 1`, saturating at 0. `base` is `pend_rate` if `pending = 1`, otherwise `rate`.
  - Successive presses accumulate.
  - `pending` is set only if the result differs from `rate`. If the result equals `rate`, `pending` clears.
  - Up and down presses in the same cycle are ignored.
- **Divider, `run = 1`.** `cnt` counts 0 … H−1, where H = `BASE_HALF << rate`.
  - At `cnt = H−1`: `cnt ← 0` and `clk_out` toggles.
  - In that same cycle, if `pending = 1`: `rate ← pend_rate` and `pending ← 0`. The new H governs the next half-period.
- **Divider, `run = 0`.** `cnt` and `clk_out` hold and `tick = 0`.
  - A queued change is applied the next cycle, and `cnt ← 0`.
  - When `run` returns to 1, counting resumes from the held `cnt`.
- **tick.** `tick ← 1` in the same cycle that `clk_out` is registered 0→1. Otherwise `tick ← 0`.
- **Arithmetic.** The compare uses an H computed at `CNT_W` bits. The rate arithmetic is 3-bit with explicit saturation and never wraps.

## Timing
- **Reset values** (when `reset = 0` at a clock edge): `cnt` = 0, `clk_out` = 0, `tick` = 0, `rate` = `RATE_INIT`, `pend_rate` = `RATE_INIT`, `pending` = 0, `btn_q` = 0.
- **Reset mid-operation:** any queued change is discarded and all outputs return to their reset values on that edge.
- **First toggle after reset:** `clk_out` first toggles H cycles after the first edge that samples `reset = 1`. The period is 2·H cycles at 50% duty.
- **Press latency:** `pending` and `pend_rate` update on the same edge that samples the button's rising edge. This is one cycle of latency, or three cycles with `BTN_SYNC_EN`.
- **Change latency:** `rate` updates at the next `cnt = H−1` edge, using the old H. Worst case is H_old cycles after the press.
- **Simultaneous events:** if a press lands on the edge where `cnt = H−1`, the previously queued value is applied. The new press is then queued for the following boundary.

## Configuration
- `CLK_RATE_CTRL_BTN_SYNC_EN` defined: `btn_up` and `btn_down` each pass through a 2-flop synchronizer (reset to 0) before edge detection. This adds 2 cycles to press latency and allows asynchronous button inputs.
- Undefined: the buttons go directly to edge detection and must already be synchronous to `clk_in`.

## Test plan
All scenarios use `BASE_HALF` = 2, `RATE_MAX` = 3, `RATE_INIT` = 0, `run` = 1, and the macro undefined unless stated. `clk_in` toggles every 1 ns.
- **Reset:** hold `reset` = 0 for 3 cycles with the buttons high → `clk_out` = 0, `tick` = 0, `rate` = 0, `pending` = 0. After release, `clk_out` toggles every 2 cycles and `tick` pulses every 4 cycles. The held buttons produce no further press until re-pressed.
- **Single up press mid half-period:** `pending` = 1 the next cycle and `rate` stays 0 until the boundary. Then `rate` = 1 and half-periods are 4 cycles, with no half-period shorter than 2.
- **Saturation:** 5 up presses → `rate` = 3 and H = 16. A down press at `rate` = 0 → `rate` stays 0 and `pending` stays 0. Presses up, up, down while pending → applied `rate` = 1.
- **Simultaneous:** `btn_up` and `btn_down` rise on the same edge → `pending` = 0 and `rate` unchanged.
- **Frozen divider:** `run` = 0 with `clk_out` = 1 → `clk_out` holds 1 and `tick` = 0. An up press → `rate` = 1 within 2 cycles and `cnt` = 0. Raising `run` → first toggle after 4 cycles.
- **Reset mid-operation:** reset while `pending` = 1 → `rate` = 0 and `pending` = 0. Repeat the reset scenario with the macro defined and confirm a 3-cycle press latency.
